// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the gshare predictor: counter encodings,
// default geometry and the saturating counter step.
package branch_predictor_pkg;

  localparam int IDX_BITS_DEF = 5;
  localparam int GHR_BITS_DEF = 5;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } counter_e;

  function automatic counter_e next_counter(counter_e cnt, logic taken);
    logic [1:0] raw;
    raw = cnt;
    if (taken) begin
      if (cnt != ST) raw = raw + 2'd1;
    end else begin
      if (cnt != SNT) raw = raw - 2'd1;
    end
    return counter_e'(raw);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side training signals of the branch predictor.
// The core is the master; the predictor is the slave.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int GHR_BITS = GHR_BITS_DEF
);
  logic [31:0]         if_pc;
  logic [31:0]         pred_next_pc;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;

  logic                upd_valid;
  logic                upd_is_cond;
  logic [31:0]         upd_pc;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_taken;
  logic [31:0]         upd_target;
  logic [31:0]         upd_pred_next_pc;

  logic                mispredict;
  logic [31:0]         correct_pc;

  modport master (
    output if_pc, upd_valid, upd_is_cond, upd_pc, upd_ghr, upd_taken,
           upd_target, upd_pred_next_pc,
    input  pred_next_pc, pred_taken, pred_ghr, mispredict, correct_pc
  );

  modport slave (
    input  if_pc, upd_valid, upd_is_cond, upd_pc, upd_ghr, upd_taken,
           upd_target, upd_pred_next_pc,
    output pred_next_pc, pred_taken, pred_ghr, mispredict, correct_pc
  );
endinterface

// File: rtl/branch_predictor_pattern_history_table.sv
// Array of 2-bit saturating direction counters, cleared to weakly-not-taken.
// One asynchronous read port, one saturating-update write port.
module pattern_history_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output counter_e            rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int ENTRIES = 1 << IDX_BITS;

  counter_e cnt_q [ENTRIES];

  // NOTE: every counter needs a known start value, so this array is reset in
  // full; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= next_counter(cnt_q[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB. Predicts next_pc from
// the fetch PC with zero latency; trained by EX when a branch/jump resolves.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int GHR_BITS = GHR_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic [GHR_BITS-1:0] ghr_q;
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_W-1:0]    btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic                btb_jump   [ENTRIES];

  logic [IDX_BITS-1:0] bidx, pidx, uidx, upidx;
  logic [TAG_W-1:0]    if_tag;
  counter_e            rd_cnt;
  logic                hit, btb_wr, pht_wr;

  assign bidx   = bp.if_pc[IDX_BITS+1:2];
  assign if_tag = bp.if_pc[31:IDX_BITS+2];
  assign pidx   = bidx ^ ghr_q;
  assign uidx   = bp.upd_pc[IDX_BITS+1:2];
  assign upidx  = uidx ^ bp.upd_ghr;
  assign btb_wr = bp.upd_valid && bp.upd_taken;
  assign pht_wr = bp.upd_valid && bp.upd_is_cond;

  pattern_history_table #(.IDX_BITS(IDX_BITS)) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pidx),
    .rd_cnt   (rd_cnt),
    .wr_en    (pht_wr),
    .wr_idx   (upidx),
    .wr_taken (bp.upd_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q     <= '0;
      btb_valid <= '0;
    end else begin
      if (pht_wr) ghr_q <= {ghr_q[GHR_BITS-2:0], bp.upd_taken};
      if (btb_wr) btb_valid[uidx] <= 1'b1;
    end
  end

  // Payload is qualified by btb_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && btb_wr) begin
      btb_tag[uidx]    <= bp.upd_pc[31:IDX_BITS+2];
      btb_target[uidx] <= bp.upd_target;
      btb_jump[uidx]   <= !bp.upd_is_cond;
    end
  end

  // Outputs are masked while reset is held so they reflect the cleared state.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    hit             = 1'b0;
    bp.pred_taken   = 1'b0;
    bp.pred_next_pc = bp.if_pc + 32'd4;
    bp.pred_ghr     = '0;
    if (!reset) begin
      hit           = btb_valid[bidx] && (btb_tag[bidx] == if_tag);
      bp.pred_taken = hit && (btb_jump[bidx] || (rd_cnt inside {WT, ST}));
      bp.pred_ghr   = ghr_q;
      if (bp.pred_taken) bp.pred_next_pc = btb_target[bidx];
    end
  end

  assign bp.correct_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
  assign bp.mispredict = bp.upd_valid && (bp.correct_pc != bp.upd_pred_next_pc);

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Gshare direction predictor plus direct-mapped BTB. Sits upstream of the IF stage and drives the PC register's next_pc input each cycle.
- Predicts from the current fetch PC. It is trained non-speculatively by the EX stage when a branch or jump resolves.
- Flags mispredictions so the core can flush IF/ID and ID/EX and redirect the PC.

Parameters:
- IDX_BITS, 5, log2 of BTB/PHT entries (32); index = pc[IDX_BITS+1:2]
- GHR_BITS, 5, global history length; must equal IDX_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_pc  in  32  current fetch PC
- pred_next_pc  out  32  predicted next fetch PC
- pred_taken  out  1  prediction is taken (BTB target selected)
- pred_ghr  out  GHR_BITS  GHR snapshot used for this prediction; core carries it down the pipeline
- upd_valid  in  1  EX stage resolves a branch/jal/jalr this cycle (not asserted for flushed bubbles)
- upd_is_cond  in  1  resolved instruction is a conditional branch
- upd_pc  in  32  PC of resolved instruction
- upd_ghr  in  GHR_BITS  pred_ghr carried with that instruction
- upd_taken  in  1  actual outcome (1 for jal/jalr)
- upd_target  in  32  actual target when taken
- upd_pred_next_pc  in  32  pred_next_pc carried with that instruction
- mispredict  out  1  combinational, upd_valid and actual next PC differs from upd_pred_next_pc
- correct_pc  out  32  actual next PC: upd_taken ? upd_target : upd_pc+4

Behaviour:
- State:
  - GHR, GHR_BITS bits.
  - PHT of 2^IDX_BITS 2-bit saturating counters: 0 SNT, 1 WNT, 2 WT, 3 ST.
  - BTB entries: valid, tag = pc[31:IDX_BITS+2], target[31:0], is_jump.
- Reset:
  - GHR=0, every PHT counter=1 (WNT), every BTB valid=0.
  - Reset asserted mid-operation discards all training. The same-edge update is dropped.
  - During reset, outputs follow the cleared state: pred_next_pc=if_pc+4, pred_taken=0, pred_ghr=0.
- Prediction, combinational from if_pc and registered state, zero latency:
  - bidx = if_pc[IDX_BITS+1:2]
  - pidx = bidx XOR GHR
  - hit = valid[bidx] and tag match
  - pred_taken = hit and (is_jump[bidx] or PHT[pidx][1])
  - pred_next_pc = pred_taken ? target[bidx] : if_pc+4 (32-bit wrap)
  - pred_ghr = GHR
- Update at posedge clk when upd_valid and not reset:
  - BTB: if upd_taken, write entry at upd_pc index with valid=1, tag, target=upd_target, is_jump=!upd_is_cond. This overwrites any conflicting tag. Not-taken outcomes never allocate or evict.
  - PHT: only if upd_is_cond. Index = upd_pc[IDX_BITS+1:2] XOR upd_ghr. Increment on taken, saturating at 3; decrement on not-taken, saturating at 0.
  - GHR: only if upd_is_cond. GHR <= {GHR[GHR_BITS-2:0], upd_taken}. Jumps do not shift history.
- Same-cycle read/write of the same entry: the prediction uses pre-edge state. There is no write-to-read bypass.
- mispredict:
  - Combinational, independent of update.
  - Compares correct_pc with upd_pred_next_pc, so taken-to-wrong-target (jalr) counts as a mispredict.
- Only one update per cycle; EX resolves at most one instruction.
- Non-taken predictions for a BTB miss are always if_pc+4, including for jal. A first-time jal therefore mispredicts once.

Decomposition:
- Shared package holds:
  - counter encodings SNT/WNT/WT/ST
  - IDX_BITS/GHR_BITS defaults
  - helper for next_counter(cnt, taken)
- Sub-module: pattern_history_table.
  - Counter array with reset-to-WNT.
  - One combinational read port and one saturating-update write port.
- BTB and GHR stay in branch_predictor.

Test Plan:
- Reset then if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104, pred_ghr=0.
- Taken cond update: upd_pc=0x100, upd_target=0x80, upd_ghr=0, upd_pred_next_pc=0x104.
  - Same cycle: mispredict=1, correct_pc=0x80.
  - Next cycle: GHR=1, PHT[0]=2 (index 0x00^0), BTB[0] valid.
  - if_pc=0x104 (bidx 1, pidx 1^1=0) then pred_taken=0, since tag/idx 1 is empty.
- Counter saturation: 4 taken updates at pidx 3 -> counter 3. Then one not-taken -> 2, and prediction is still taken.
- jal training: upd_is_cond=0, upd_taken=1, upd_pc=0x20, target=0x200 -> GHR unchanged. Then if_pc=0x20 -> pred_next_pc=0x200 regardless of PHT.
- Alias eviction: train 0x100->0x80, then 0x180 (same index, different tag) ->0x40. if_pc=0x100 then misses (pred_next_pc=0x104).
- Reset asserted on the same edge as upd_valid -> all state cleared, no entry written. Next if_pc=0x20 -> 0x24.
